// File: rtl/imem_loader.sv
// imem_loader: fills instruction memory from a byte stream. The stream is a
// little-endian 16-bit word count followed by the image bytes. Bytes are
// assembled little-endian into words, and each word is written at sequential
// addresses from 0. busy holds the core in reset while a load is in progress.
module imem_loader #(
   parameter int DWIDTH = 32,
   parameter int AWIDTH = 5
) (
   input  logic              clock,
   input  logic              n_reset,
   input  logic              start,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic              we,
   output logic [AWIDTH-1:0] waddr,
   output logic [DWIDTH-1:0] wdata,
   output logic              busy,
   output logic              done,
   output logic              error
);

   localparam int NB = DWIDTH / 8;
   localparam int BW = (NB > 1) ? $clog2(NB) : 1;
   // Depth is held in 17 bits so it compares cleanly against the 16-bit count.
   localparam logic [16:0] DEPTH = 17'(1) << AWIDTH;

   typedef enum logic [2:0] {
      IDLE, LEN0, LEN1, DATA, FLUSH, DONE, ERROR
   } state_t;

   state_t            state, state_next;
   logic [15:0]       count;
   logic [15:0]       word_cnt;
   logic [BW-1:0]     byte_cnt;
   logic [AWIDTH-1:0] addr;
   logic [DWIDTH-1:0] asm_word, asm_next;
   logic [15:0]       len_full;
   logic              accept;
   logic              last_byte;
   logic              last_word;

   assign accept    = rx_valid && rx_ready;
   assign last_byte = (byte_cnt == BW'(NB - 1));
   assign last_word = (word_cnt == count - 16'd1);
   // Full count as it will be once the LEN1 byte lands.
   assign len_full  = {rx_data, count[7:0]};

   // Insert the incoming byte into its little-endian lane of the assembly word.
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      asm_next = asm_word;
      for (int k = 0; k < NB; k++) begin
         if (byte_cnt == BW'(k)) asm_next[8*k +: 8] = rx_data;
      end
   end

   // State register.
   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) state <= IDLE;
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of process ordering.
      else          state <= state_next;
   end

   // Next-state logic.
   always_comb begin
      state_next = state;
      case (state)
         IDLE, DONE, ERROR: if (start) state_next = LEN0;
         LEN0:              if (accept) state_next = LEN1;
         LEN1: begin
            if (accept) begin
               if (len_full == 16'd0)               state_next = DONE;
               else if ({1'b0, len_full} > DEPTH)   state_next = ERROR;
               else                                 state_next = DATA;
            end
         end
         DATA:              if (accept && last_byte && last_word) state_next = FLUSH;
         FLUSH:             state_next = DONE;
         default:           state_next = IDLE;
      endcase
   end

   // Status outputs decoded from the state.
   always_comb begin
      rx_ready = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      error    = 1'b0;
      case (state)
         LEN0, LEN1, DATA: begin
            rx_ready = 1'b1;
            busy     = 1'b1;
         end
         FLUSH:   busy  = 1'b1;
         DONE:    done  = 1'b1;
         ERROR:   error = 1'b1;
         default: ;
      endcase
   end

   // Datapath: length capture, word assembly, counters and the write port.
   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         count    <= '0;
         word_cnt <= '0;
         byte_cnt <= '0;
         addr     <= '0;
         asm_word <= '0;
         we       <= 1'b0;
         waddr    <= '0;
         wdata    <= '0;
      end else begin
         we <= 1'b0;
         case (state)
            IDLE, DONE, ERROR: begin
               if (start) begin
                  word_cnt <= '0;
                  byte_cnt <= '0;
                  addr     <= '0;
               end
            end
            LEN0: if (accept) count[7:0]  <= rx_data;
            LEN1: if (accept) count[15:8] <= rx_data;
            DATA: begin
               if (accept) begin
                  asm_word <= asm_next;
                  if (last_byte) begin
                     // Word complete: present it on the write port next cycle.
                     byte_cnt <= '0;
                     wdata    <= asm_next;
                     waddr    <= addr;
                     we       <= 1'b1;
                     // Wraps to 0 after a full-depth load; harmless.
                     addr     <= addr + 1'b1;
                     word_cnt <= word_cnt + 16'd1;
                  end else begin
                     byte_cnt <= byte_cnt + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: expected writes are queued as the image
// is driven and popped by a monitor whenever we is seen high.
module tb_imem_loader;

   localparam int DW = 32;
   localparam int AW = 5;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   logic          clock = 1'b0;
   logic          n_reset = 1'b0;
   logic          start = 1'b0;
   logic [7:0]    rx_data = '0;
   logic          rx_valid = 1'b0;
   logic          rx_ready;
   logic          we;
   logic [AW-1:0] waddr;
   logic [DW-1:0] wdata;
   logic          busy;
   logic          done;
   logic          error;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int we_total = 0;
   wr_t sb[$];
   int  we_cycles[$];
   logic [DW-1:0] img [0:63];

   imem_loader #(.DWIDTH(DW), .AWIDTH(AW)) dut (
      .clock    (clock),
      .n_reset  (n_reset),
      .start    (start),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .we       (we),
      .waddr    (waddr),
      .wdata    (wdata),
      .busy     (busy),
      .done     (done),
      .error    (error)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc++;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Write-port monitor, sampled on the falling edge.
   always @(negedge clock) begin
      if (we === 1'b1) begin
         we_total++;
         we_cycles.push_back(cyc);
         if (sb.size() == 0) begin
            check("unexpected_we", 1, 0);
         end else begin
            wr_t e;
            e = sb.pop_front();
            check("waddr", 64'(waddr), 64'(e.addr));
            check("wdata", 64'(wdata), 64'(e.data));
         end
      end
   end

   task automatic pulse_start();
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
   endtask

   // Present one byte after 'gap' idle cycles; returns on the falling edge
   // before the rising edge that transfers it.
   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      for (int i = 0; i < gap; i++) begin
         @(negedge clock);
         rx_valid = 1'b0;
      end
      @(negedge clock);
      rx_valid = 1'b1;
      rx_data  = b;
      n = 0;
      while (rx_ready !== 1'b1 && n < 100) begin
         @(negedge clock);
         n++;
      end
      if (n >= 100) check("rx_ready_timeout", 64'(rx_ready), 1);
   endtask

   task automatic send_count(input logic [15:0] cnt);
      send_byte(cnt[7:0], 0);
      send_byte(cnt[15:8], 0);
   endtask

   // Stream words first..last of img, queueing the expected writes.
   task automatic send_words(input int first, input int last, input int gapmax);
      logic [DW-1:0] w;
      for (int i = first; i <= last; i++) begin
         wr_t e;
         e.addr = AW'(i);
         e.data = img[i];
         sb.push_back(e);
         w = img[i];
         for (int k = 0; k < DW/8; k++) begin
            send_byte(w[8*k +: 8], (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0);
         end
      end
   endtask

   // After the final byte: FLUSH with we high, then DONE.
   task automatic finish_load(input string tag);
      @(negedge clock);
      rx_valid = 1'b0;
      check({tag, "_flush_we"}, 64'(we), 1);
      check({tag, "_flush_busy"}, 64'(busy), 1);
      check({tag, "_flush_rx_ready"}, 64'(rx_ready), 0);
      @(negedge clock);
      check({tag, "_done"}, 64'(done), 1);
      check({tag, "_busy_low"}, 64'(busy), 0);
      check({tag, "_rx_ready_low"}, 64'(rx_ready), 0);
      check({tag, "_error_low"}, 64'(error), 0);
      check({tag, "_sb_empty"}, 64'(sb.size()), 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rx_ready"}, 64'(rx_ready), 0);
      check({tag, "_we"}, 64'(we), 0);
      check({tag, "_waddr"}, 64'(waddr), 0);
      check({tag, "_wdata"}, 64'(wdata), 0);
      check({tag, "_busy"}, 64'(busy), 0);
      check({tag, "_done"}, 64'(done), 0);
      check({tag, "_error"}, 64'(error), 0);
   endtask

   initial begin
      int base;

      // Reset state.
      #12;
      check_reset_outputs("reset");
      @(negedge clock);
      n_reset = 1'b1;

      // Single word image.
      pulse_start();
      check("start_busy", 64'(busy), 1);
      check("start_rx_ready", 64'(rx_ready), 1);
      img[0] = 32'h00A0_0513;
      send_count(16'd1);
      send_words(0, 0, 0);
      finish_load("one");
      check("one_we_count", 64'(we_total), 1);

      // Three words at full rate, writes spaced 4 cycles apart.
      img[0] = 32'h1111_1111;
      img[1] = 32'h2222_2222;
      img[2] = 32'h3333_3333;
      base = we_total;
      we_cycles.delete();
      pulse_start();
      send_count(16'd3);
      send_words(0, 2, 0);
      finish_load("three");
      check("three_we_count", 64'(we_total - base), 3);
      check("three_space01", 64'(we_cycles[1] - we_cycles[0]), 4);
      check("three_space12", 64'(we_cycles[2] - we_cycles[1]), 4);

      // Full depth with random gaps.
      for (int i = 0; i < 32; i++) img[i] = $urandom;
      base = we_total;
      pulse_start();
      send_count(16'd32);
      send_words(0, 31, 3);
      finish_load("full");
      check("full_we_count", 64'(we_total - base), 32);

      // Count one beyond depth.
      base = we_total;
      pulse_start();
      send_count(16'd33);
      @(negedge clock);
      rx_valid = 1'b0;
      check("ovf_error", 64'(error), 1);
      check("ovf_busy", 64'(busy), 0);
      check("ovf_done", 64'(done), 0);
      repeat (3) @(negedge clock);
      check("ovf_rx_ready", 64'(rx_ready), 0);
      check("ovf_no_we", 64'(we_total - base), 0);

      // Recovery load clears error.
      img[0] = 32'hCAFE_F00D;
      img[1] = 32'h0BAD_BEEF;
      pulse_start();
      check("recover_error_cleared", 64'(error), 0);
      send_count(16'd2);
      send_words(0, 1, 1);
      finish_load("recover");

      // Zero count: done straight after LEN1.
      base = we_total;
      pulse_start();
      send_count(16'd0);
      @(negedge clock);
      rx_valid = 1'b0;
      check("zero_done", 64'(done), 1);
      check("zero_busy", 64'(busy), 0);
      repeat (2) @(negedge clock);
      check("zero_no_we", 64'(we_total - base), 0);

      // Start pulse in the middle of DATA is ignored.
      img[0] = 32'hA5A5_5A5A;
      img[1] = 32'h0123_4567;
      pulse_start();
      send_count(16'd2);
      send_words(0, 0, 0);
      @(negedge clock);
      rx_valid = 1'b0;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      check("midstart_busy", 64'(busy), 1);
      check("midstart_rx_ready", 64'(rx_ready), 1);
      send_words(1, 1, 0);
      finish_load("midstart");

      // Asynchronous reset after 2 of 4 words.
      for (int i = 0; i < 4; i++) img[i] = 32'hD000_0000 | 32'(i);
      pulse_start();
      send_count(16'd4);
      send_words(0, 1, 0);
      @(negedge clock);
      rx_valid = 1'b0;
      #2;
      n_reset = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      check("async_rst_sb_empty", 64'(sb.size()), 0);
      @(negedge clock);
      n_reset = 1'b1;
      img[0] = 32'h7777_8888;
      pulse_start();
      send_count(16'd1);
      send_words(0, 0, 0);
      finish_load("reload");

      repeat (2) @(negedge clock);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global time bound.
   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
